// File: rtl/iir_capture_pkg.sv
// Shared types and defaults for the iir_capture trigger/record block.
// Optional decimation is enabled with the IIR_CAPTURE_DECIM_EN macro in iir_capture.
package iir_capture_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 256;
    localparam int AW            = $clog2(DEPTH_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample-pair store: synchronous write, synchronous read, no array reset.
// Read data holds while rd_en is low, which the read pipeline relies on for stalls.
module capture_ram
    import iir_capture_pkg::*;
#(
    parameter int W      = 2 * DW_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output holds when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/iir_capture.sv
// Triggered (x, y) capture buffer with pre-trigger window and oldest-first valid/ready readout.
// Define IIR_CAPTURE_DECIM_EN to add parameter DECIM and keep only every DECIM-th valid sample.
module iir_capture
    import iir_capture_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int PRE_TRIG = 64
`ifdef IIR_CAPTURE_DECIM_EN
    ,
    parameter int DECIM    = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   x_in,
    input  logic [DW-1:0]   y_in,
    input  logic            arm,
    input  logic [DW-1:0]   trig_level,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [2*DW-1:0] rd_data,
    output logic            rd_last,
    output logic            busy,
    output logic            triggered
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CW     = ADDR_W + 1;
    localparam int POST_N = DEPTH - PRE_TRIG;

    localparam logic [CW-1:0] PRE_LAST   = (PRE_TRIG > 0) ? CW'(PRE_TRIG - 1) : '0;
    localparam logic [CW-1:0] POST_LAST  = CW'(POST_N - 1);
    localparam logic [CW-1:0] LAST_ISSUE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic signed [DW-1:0] Y_MIN = {1'b1, {(DW - 1){1'b0}}};

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_W-1:0]      wr_ptr_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          issue_cnt_r;
    logic                   q_valid_r;
    logic                   q_last_r;
    logic signed [DW-1:0]   prev_y_r;
    logic signed [DW-1:0]   level_r;
    logic                   rd_valid_r;
    logic [2*DW-1:0]        rd_data_r;
    logic                   rd_last_r;
    logic                   busy_r;
    logic                   triggered_r;

    logic signed [DW-1:0]   y_s;
    logic                   arm_ok_s;
    logic                   capturing_s;
    logic                   decim_hit_s;
    logic                   sample_s;
    logic                   trig_hit_s;
    logic                   out_load_s;
    logic                   rd_en_s;
    logic                   rd_fire_s;
    logic [ADDR_W-1:0]      rd_addr_s;
    logic [2*DW-1:0]        ram_q_s;

    assign y_s         = $signed(y_in);
    assign arm_ok_s    = arm && (state_r == ST_IDLE);
    assign capturing_s = (state_r == ST_PRE) || (state_r == ST_ARMED) || (state_r == ST_POST);
    assign sample_s    = in_valid && capturing_s && decim_hit_s;
    // Trigger compare only in ARMED, so crossings seen during PRE are ignored.
    assign trig_hit_s  = sample_s && (state_r == ST_ARMED)
                         && (prev_y_r < level_r) && (y_s >= level_r);

`ifdef IIR_CAPTURE_DECIM_EN
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DCW-1:0] decim_cnt_r;

    assign decim_hit_s = (decim_cnt_r == DCW'(DECIM - 1));

    // Decimation phase: restarts on arm, advances on every valid sample while capturing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decim_cnt_r <= '0;
        end else if (arm_ok_s) begin
            decim_cnt_r <= '0;
        end else if (in_valid && capturing_s) begin
            decim_cnt_r <= decim_hit_s ? '0 : decim_cnt_r + DCW'(1);
        end
    end
`else
    assign decim_hit_s = 1'b1;
`endif

    // Read side: the RAM output acts as a one-entry prefetch stage behind rd_data.
    assign out_load_s = q_valid_r && (!rd_valid_r || rd_ready);
    assign rd_en_s    = (state_r == ST_READ) && (issue_cnt_r != DEPTH_CNT)
                        && (!q_valid_r || out_load_s);
    assign rd_fire_s  = rd_valid_r && rd_ready;
    assign rd_addr_s  = wr_ptr_r + issue_cnt_r[ADDR_W-1:0];

    // Next-state decode for the capture sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    state_s = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (sample_s && (cnt_r == PRE_LAST)) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_PRE;
                end
            end
            ST_ARMED: begin
                if (trig_hit_s) begin
                    state_s = (POST_N == 1) ? ST_READ : ST_POST;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_POST: begin
                if (sample_s && (cnt_r == POST_LAST)) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_POST;
                end
            end
            ST_READ: begin
                if (rd_fire_s && rd_last_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            triggered_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            if (state_s == ST_IDLE) begin
                triggered_r <= 1'b0;
            end else if (trig_hit_s) begin
                triggered_r <= 1'b1;
            end
        end
    end

    // Write pointer, stage counter, trigger history and latched threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            cnt_r    <= '0;
            prev_y_r <= '0;
            level_r  <= '0;
        end else begin
            if (sample_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (arm_ok_s) begin
                cnt_r    <= '0;
                prev_y_r <= Y_MIN;
                level_r  <= $signed(trig_level);
            end else if (sample_s) begin
                // The trigger sample is the first post sample.
                cnt_r    <= trig_hit_s ? CW'(1) : cnt_r + CW'(1);
                prev_y_r <= y_s;
            end
        end
    end

    // Read issue counter and prefetch-stage bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_r <= '0;
            q_valid_r   <= 1'b0;
            q_last_r    <= 1'b0;
        end else if (state_r != ST_READ) begin
            issue_cnt_r <= '0;
            q_valid_r   <= 1'b0;
            q_last_r    <= 1'b0;
        end else if (rd_en_s) begin
            issue_cnt_r <= issue_cnt_r + CW'(1);
            q_valid_r   <= 1'b1;
            q_last_r    <= (issue_cnt_r == LAST_ISSUE);
        end else if (out_load_s) begin
            q_valid_r   <= 1'b0;
        end
    end

    // Output register: loads from the prefetch stage, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            rd_last_r  <= 1'b0;
        end else if (out_load_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= ram_q_s;
            rd_last_r  <= q_last_r;
        end else if (rd_fire_s) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end
    end

    capture_ram #(
        .W      (2 * DW),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (sample_s),
        .wr_addr (wr_ptr_r),
        .wr_data ({x_in, y_in}),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (ram_q_s)
    );

    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_last   = rd_last_r;
    assign busy      = busy_r;
    assign triggered = triggered_r;

endmodule

// File: tb/tb_iir_capture.sv
// Scoreboard bench for iir_capture: two instances (256/64 and 16/0) share the sample stream;
// a record-level reference model queues expected readouts, a negedge monitor checks them.
module tb_iir_capture;

    localparam int DW = 8;
    localparam int D0 = 256;
    localparam int P0 = 64;
    localparam int D1 = 16;
    localparam int P1 = 0;
`ifdef IIR_CAPTURE_DECIM_EN
    localparam int DEC = 4;
`else
    localparam int DEC = 1;
`endif

    typedef logic [2*DW-1:0] pair_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 arm = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic signed [DW-1:0] y_in = '0;
    logic signed [DW-1:0] trig_level = '0;
    logic                 rr [2];
    logic                 rv [2];
    pair_t                rdat [2];
    logic                 rl [2];
    logic                 bz [2];
    logic                 tg [2];

    int n_chk = 0;
    int n_fail = 0;

    // reference model state, per instance
    int    depth_m [2];
    int    pre_m   [2];
    bit    busy_m  [2];
    bit    done_m  [2];
    bit    trig_m  [2];
    int    nst_m   [2];
    int    post_m  [2];
    int    dec_m   [2];
    int    prev_m  [2];
    int    lvl_m   [2];
    int    hs_m    [2];
    pair_t hist    [2][$];
    pair_t expq    [2][$];

    bit          stall_v [2];
    pair_t       stall_d [2];
    logic        stall_l [2];
    logic [7:0]  first_y [2];
    logic [7:0]  last_y  [2];
    pair_t       mon_e;
    int          rd_mode = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    iir_capture #(.DW(DW), .DEPTH(D0), .PRE_TRIG(P0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
        .arm(arm), .trig_level(trig_level), .rd_ready(rr[0]), .rd_valid(rv[0]),
        .rd_data(rdat[0]), .rd_last(rl[0]), .busy(bz[0]), .triggered(tg[0])
    );

    iir_capture #(.DW(DW), .DEPTH(D1), .PRE_TRIG(P1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
        .arm(arm), .trig_level(trig_level), .rd_ready(rr[1]), .rd_valid(rv[1]),
        .rd_data(rdat[1]), .rd_last(rl[1]), .busy(bz[1]), .triggered(tg[1])
    );

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Applies the capture rules to the inputs about to be sampled at the next rising edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (busy_m[d] && !done_m[d] && in_valid) begin
                dec_m[d]++;
                if (dec_m[d] == DEC) begin
                    dec_m[d] = 0;
                    if (!trig_m[d] && nst_m[d] >= pre_m[d] && prev_m[d] < lvl_m[d]
                        && int'(y_in) >= lvl_m[d]) begin
                        trig_m[d] = 1'b1;
                    end
                    hist[d].push_back({x_in, y_in});
                    if (hist[d].size() > depth_m[d]) void'(hist[d].pop_front());
                    nst_m[d]++;
                    if (trig_m[d]) post_m[d]++;
                    prev_m[d] = int'(y_in);
                    if (trig_m[d] && post_m[d] == depth_m[d] - pre_m[d]) begin
                        done_m[d] = 1'b1;
                        for (int i = 0; i < hist[d].size(); i++) expq[d].push_back(hist[d][i]);
                    end
                end
            end
            if (arm && !busy_m[d]) begin
                busy_m[d] = 1'b1;
                done_m[d] = 1'b0;
                trig_m[d] = 1'b0;
                nst_m[d]  = 0;
                post_m[d] = 0;
                dec_m[d]  = 0;
                prev_m[d] = -128;
                lvl_m[d]  = int'(trig_level);
                hist[d].delete();
            end
        end
    endtask

    task automatic drive(input bit v, input int x, input int y, input bit a);
        @(posedge clk);
        #1;
        in_valid = v;
        x_in     = x[7:0];
        y_in     = y[7:0];
        arm      = a;
        model_step();
    endtask

    function automatic int rnd_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Per-cycle read-ready pattern: 1,0,0,1 on instance 0 in mode 0, random otherwise.
    initial begin
        rr[0] = 1'b0;
        rr[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rd_mode == 0) rr[0] = (cyc % 4 == 0) || (cyc % 4 == 3);
            else              rr[0] = ($urandom_range(0, 2) != 0);
            rr[1] = $urandom_range(0, 1) != 0;
        end
    end

    // Monitor: idle checks, stall stability, and scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (rst) begin
            stall_v[0] = 1'b0;
            stall_v[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!busy_m[d]) begin
                    chk(bz[d] == 1'b0, "idle_busy", bz[d], 0);
                    chk(tg[d] == 1'b0, "idle_triggered", tg[d], 0);
                    chk(rv[d] == 1'b0, "idle_rd_valid", rv[d], 0);
                end
                if (stall_v[d]) begin
                    chk(rv[d] && rdat[d] == stall_d[d] && rl[d] == stall_l[d],
                        "stall_hold", rdat[d], stall_d[d]);
                end
                if (rv[d] && rr[d]) begin
                    if (expq[d].size() == 0) begin
                        chk(1'b0, "unexpected_pair", rdat[d], 0);
                    end else begin
                        mon_e = expq[d].pop_front();
                        if (hs_m[d] == 0) first_y[d] = rdat[d][7:0];
                        hs_m[d]++;
                        chk(rdat[d] == mon_e, "rd_data", rdat[d], mon_e);
                        chk(rl[d] == (expq[d].size() == 0), "rd_last", rl[d], expq[d].size() == 0);
                        chk(tg[d] == 1'b1, "read_triggered", tg[d], 1);
                        chk(bz[d] == 1'b1, "read_busy", bz[d], 1);
                        if (expq[d].size() == 0) begin
                            last_y[d] = rdat[d][7:0];
                            busy_m[d] = 1'b0;
                            hs_m[d]   = 0;
                        end
                    end
                end
                stall_v[d] = rv[d] && !rr[d];
                stall_d[d] = rdat[d];
                stall_l[d] = rl[d];
            end
        end
    end

    initial begin
        int n;
        int k;
        bit a;
        depth_m = '{D0, D1};
        pre_m   = '{P0, P1};
        for (int d = 0; d < 2; d++) begin
            busy_m[d] = 1'b0; done_m[d] = 1'b0; trig_m[d] = 1'b0; hs_m[d] = 0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(rv[d] == 1'b0, "reset_rd_valid", rv[d], 0);
            chk(rdat[d] == '0, "reset_rd_data", rdat[d], 0);
            chk(rl[d] == 1'b0, "reset_rd_last", rl[d], 0);
            chk(bz[d] == 1'b0, "reset_busy", bz[d], 0);
            chk(tg[d] == 1'b0, "reset_triggered", tg[d], 0);
        end

        // Ramp x = y = n, level 0, arm at n = -100; instance 0 reads with 1,0,0,1 ready.
        rd_mode = 0;
        trig_level = '0;
        n = -100;
        drive(1'b1, n, n, 1'b1);
        n++;
        k = 0;
        while ((busy_m[0] || busy_m[1]) && k < 4000) begin
            drive(1'b1, n, n, 1'b0);
            n++;
            k++;
        end
        chk(!(busy_m[0] || busy_m[1]), "ramp_timeout", k, 4000);
`ifndef IIR_CAPTURE_DECIM_EN
        chk(first_y[0] == 8'hC0, "ramp_first_y0", first_y[0], 8'hC0);
        chk(last_y[0] == 8'hBF, "ramp_last_y0", last_y[0], 8'hBF);
        chk(first_y[1] == 8'h00, "ramp_first_y1", first_y[1], 8'h00);
        chk(last_y[1] == 8'h0F, "ramp_last_y1", last_y[1], 8'h0F);
`endif

        // Reset during readout after 10 pairs, then capture again.
        rd_mode = 1;
        trig_level = 8'(rnd_s8() / 2);
        drive(1'b1, rnd_s8(), rnd_s8(), 1'b1);
        k = 0;
        while (!(done_m[0] && hs_m[0] >= 10) && k < 4000) begin
            drive($urandom_range(0, 3) != 0, rnd_s8(), rnd_s8(), 1'b0);
            k++;
        end
        chk(done_m[0] && hs_m[0] >= 10, "midread_timeout", hs_m[0], 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        arm = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(rv[d] == 1'b0, "midreset_rd_valid", rv[d], 0);
            chk(bz[d] == 1'b0, "midreset_busy", bz[d], 0);
            busy_m[d] = 1'b0; done_m[d] = 1'b0; trig_m[d] = 1'b0; hs_m[d] = 0;
            expq[d].delete();
            hist[d].delete();
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Arm with y already at/above level, then random traffic with stray arms while busy.
        trig_level = 8'sd10;
        drive(1'b1, rnd_s8(), 50, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, rnd_s8(), int'($urandom_range(10, 127)), 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, rnd_s8(), -int'($urandom_range(1, 100)), 1'b0);
        for (int i = 0; i < 5000; i++) begin
            a = ($urandom_range(0, 39) == 0);
            if (a) trig_level = 8'(rnd_s8() / 2);
            drive($urandom_range(0, 4) != 0, rnd_s8(), rnd_s8(), a);
        end
        k = 0;
        while ((busy_m[0] || busy_m[1]) && k < 6000) begin
            drive($urandom_range(0, 4) != 0, rnd_s8(), rnd_s8(), 1'b0);
            k++;
        end
        chk(!(busy_m[0] || busy_m[1]), "drain_timeout", k, 6000);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
